mem_wait_responder: RTL

Memory-side responder for the multicycle CPU's single-port memory bus. It accepts one read or write request at a time from the control path and stores data in an internal word array. It returns read data after a fixed, parameterised number of wait cycles, so the initiator's wait-state count and the memory latency are matched by construction. It sits between the CPU datapath (address mux, MDR/IR load) and the instruction/data storage.

---
 rtl/mem_resp_pkg.sv | 25 ++
 rtl/mem_wait_responder_if.sv | 31 +++
 rtl/mem_word_array.sv | 51 +++++
 rtl/mem_wait_responder.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared types and constants for the memory wait responder
//
// Contents:
//   state_e           responder FSM state (IDLE, WAIT, RESP), 2 bits
//   READ_LAT_DEFAULT  read latency in rising edges; equals the CPU fetch wait count
//   MEM_READ/MEM_WRITE  req_write encoding, same polarity as the CPU's MemReadWrite
//   is_misaligned()   true when a byte address is not word aligned
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int READ_LAT_DEFAULT = 3;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_wait_responder_if.sv
// rtl/mem_wait_responder_if.sv - request/response bus between CPU control path and memory
//
// Signals:
//   req_valid, req_write, req_addr[31:0], req_wdata[31:0]  initiator -> responder
//   req_ready, rsp_valid, rsp_rdata[31:0], busy, addr_err   responder -> initiator
// Modports:
//   master  the CPU side (drives the request)
//   slave   the memory responder
interface mem_wait_responder_if;

  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic        addr_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy, addr_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy, addr_err
  );

endinterface

// File: rtl/mem_word_array.sv
// rtl/mem_word_array.sv - 2**ADDR_W x 32 word storage with a registered read port
//
// Ports:
//   clk          rising-edge clock
//   clr          synchronous clear of the read register only (storage is never cleared)
//   we, widx, wdata  synchronous write; the written word is also loaded into the read register
//   re, ridx     load the read register from storage[ridx]
//   rdata        read register output
// Priority on the read register: clr, then we (write echo), then re.
module mem_word_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] widx,
  input  logic [31:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] ridx,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[widx] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (clr) begin
      rdata_d = '0;
    end else if (we) begin
      rdata_d = wdata;
    end else if (re) begin
      rdata_d = mem_q[ridx];
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_wait_responder.sv
// rtl/mem_wait_responder.sv - single-port memory responder with fixed read wait cycles
//
// Parameters:
//   ADDR_W    word-address bits; storage is 2**ADDR_W x 32
//   READ_LAT  rising edges from request presentation to read response, 1..15
// Ports:
//   clock     rising-edge system clock
//   reset     synchronous, active-high
//   bus       mem_wait_responder_if.slave (request in, response out)
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   defined   misaligned requests skip the array and respond once with addr_err=1, rsp_rdata=0
//   undefined req_addr[1:0] is ignored and addr_err is tied low
module mem_wait_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = READ_LAT_DEFAULT
) (
  input logic                  clock,
  input logic                  reset,
  mem_wait_responder_if.slave  bus
);

  localparam int CNT_W = 4;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              err_q, err_d;

  logic              accept;
  logic              misaligned;
  logic [ADDR_W-1:0] req_idx;

  logic              arr_we;
  logic              arr_re;
  logic              arr_clr;
  logic [ADDR_W-1:0] arr_ridx;
  logic [31:0]       arr_rdata;

  // Upper address bits are dropped, so addresses alias modulo 2**(ADDR_W+2) bytes.
  assign req_idx = bus.req_addr[ADDR_W+1:2];

  assign bus.req_ready = (state_q == IDLE) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned   = is_misaligned(bus.req_addr);
  assign bus.addr_err = err_q;
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.req_addr[31:ADDR_W+2];
`else
  assign misaligned   = 1'b0;
  assign bus.addr_err = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.req_addr[31:ADDR_W+2], bus.req_addr[1:0], err_q};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    err_d    = err_q;
    arr_we   = 1'b0;
    arr_re   = 1'b0;
    arr_clr  = reset;
    arr_ridx = idx_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d   = req_idx;
          state_d = RESP;
          if (misaligned) begin
            // Response register is zeroed; storage is left untouched.
            arr_clr = 1'b1;
            err_d   = 1'b1;
          end else if (bus.req_write == MEM_WRITE) begin
            // Committed at the accept edge; the read register echoes the word.
            arr_we = 1'b1;
          end else if (READ_LAT == 1) begin
            arr_re   = 1'b1;
            arr_ridx = req_idx;
          end else begin
            cnt_d   = CNT_W'(READ_LAT - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // The edge that takes the counter to zero is the one that fetches the data.
        if (cnt_q == CNT_W'(1)) begin
          arr_re  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  mem_word_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clock),
    .clr   (arr_clr),
    .we    (arr_we),
    .widx  (req_idx),
    .wdata (bus.req_wdata),
    .re    (arr_re),
    .ridx  (arr_ridx),
    .rdata (arr_rdata)
  );

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_rdata = arr_rdata;

endmodule
